instr_prefetch_buffer: RTL and testbench
========================================

// Module: instr_prefetch_buffer
// PURPOSE
//  Fetch stage feeding the decoder, upstream of instruction_memory. Walks a word-aligned PC,
//  issues req/gnt/rvalid transactions to instruction memory and buffers returned words with
//  their addresses in a FIFO. Decoder pops via valid/ready. A branch redirect flushes the
//  buffer and drops stale in-flight data.
// PARAMETERS
//  ADDR_WIDTH  8   byte-address width, shared with instruction_memory
//  DATA_WIDTH  32  instruction word width; fetch stride STEP = DATA_WIDTH/8 bytes
//  FIFO_DEPTH  4   buffered entries (power of two, >=2)
//  BOOT_ADDR   0   first fetch address after reset (word aligned)
// PORTS
//  clk             in   1           clock
//  rst_i           in   1           synchronous reset, active-high
//  instr_req_o     out  1           request to instruction memory
//  instr_addr_o    out  ADDR_WIDTH  request byte address, low log2(STEP) bits always 0
//  instr_gnt_i     in   1           grant pulse, address accepted
//  instr_rvalid_i  in   1           read-data valid pulse
//  instr_rdata_i   in   DATA_WIDTH  read data, sampled only when instr_rvalid_i=1
//  branch_i        in   1           redirect request, single-cycle
//  branch_addr_i   in   ADDR_WIDTH  redirect target; low log2(STEP) bits forced to 0
//  fetch_valid_o   out  1           FIFO head valid
//  fetch_rdata_o   out  DATA_WIDTH  FIFO head instruction
//  fetch_addr_o    out  ADDR_WIDTH  FIFO head byte address
//  fetch_ready_i   in   1           decoder pops head when fetch_valid_o & fetch_ready_i
//  busy_o          out  1           transaction outstanding (state != IDLE)
// BEHAVIOUR
//  - Reset: all outputs 0 except instr_addr_o = BOOT_ADDR. FIFO empty, PC = BOOT_ADDR,
//    discard flag cleared, state IDLE. Reset overrides everything, mid-transaction
//    included. instruction_memory is reset in the same cycle.
//  - FSM states and transitions:
//    IDLE: go to WAIT_GNT and assert req when (count + 0) < FIFO_DEPTH, i.e. a free slot.
//      First req is asserted the cycle after rst_i drops.
//    WAIT_GNT: hold instr_req_o=1 and instr_addr_o stable; never withdraw the request.
//      On gnt: drop req next cycle, PC += STEP, go to WAIT_RVALID.
//    WAIT_RVALID: req=0. On rvalid: push {PC_of_txn, rdata} unless discard is set, then
//      clear discard and return to IDLE. Back-to-back re-request is allowed from IDLE.
//  - One transaction outstanding at most. Issue gate is count < FIFO_DEPTH, so a response
//    always has a slot.
//  - PC arithmetic is modulo 2^ADDR_WIDTH: the top word wraps to 0, with no error.
//  - FIFO: first-word fall-through. fetch_* are driven from the head register; empty gives
//    fetch_valid_o=0 and rdata/addr hold their last value.
//  - Push and pop in the same cycle: count unchanged, order preserved.
//  - branch_i (highest priority after reset):
//    - FIFO flushed that cycle (count := 0, pop ignored); fetch_valid_o=0 next cycle.
//    - PC := branch_addr_i & ~(STEP-1).
//    - In WAIT_GNT: the request continues at the old address, discard := 1.
//    - In WAIT_RVALID: discard := 1.
//    - In IDLE: no flag is set; the next request uses the new PC.
//    - rvalid in the same cycle as branch_i is discarded; the flag is not left set.
//    - A branch during a discard keeps discard=1 and updates the PC again.
//  - gnt outside WAIT_GNT and rvalid outside WAIT_RVALID are ignored.
//  - Latency: from branch_i to fetch_valid_o is at least 2 + memory grant + response delay.
// TESTING
//  1. Reset, memory holds 0x00D00113 @0 and 0x00900093 @4, ready=1
//     -> pops (0x00,0x00D00113) then (0x04,0x00900093), in order.
//  2. ready=0 -> exactly FIFO_DEPTH=4 requests issued, then req stays 0.
//     Pop one -> exactly one new request, at addr 0x10.
//  3. branch_i with target 0x81 while in WAIT_RVALID for addr 0x08
//     -> that word is dropped, next request addr = 0x80, first pop = (0x80, mem[32]).
//  4. branch_i in WAIT_GNT -> req held at the old address until gnt, the response is
//     discarded, and the following request uses the branch target.
//  5. PC = 0xFC (ADDR_WIDTH=8) -> next request addr = 0x00, fetch_addr_o = 0x00.
//  6. rst_i asserted mid WAIT_RVALID with 3 entries buffered -> next cycle fetch_valid_o=0,
//     req=0, addr=BOOT_ADDR. The first request after release goes to BOOT_ADDR.

Source files
------------

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: walks a word-aligned PC, runs one req/gnt/rvalid
// transaction at a time against instruction memory and queues {addr, word}
// pairs in a small first-word-fall-through FIFO for the decoder.
module instr_prefetch_buffer #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_i,
  output logic                  instr_req_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [DATA_WIDTH-1:0] instr_rdata_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  output logic                  fetch_valid_o,
  output logic [DATA_WIDTH-1:0] fetch_rdata_o,
  output logic [ADDR_WIDTH-1:0] fetch_addr_o,
  input  logic                  fetch_ready_i,
  output logic                  busy_o
);

  localparam int STEP = DATA_WIDTH / 8;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] STEP_A  = ADDR_WIDTH'(STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_M = ~(STEP_A - ADDR_WIDTH'(1));

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;   // address of the transaction in flight
  logic                  disc_q, disc_d;   // drop the response of the current txn
  logic                  push, pop;

  logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr_q [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr_q, wr_ptr_q, rd_nxt;
  logic [CW-1:0]         count_q, cnt_nxt;
  logic [DATA_WIDTH-1:0] head_data_q;
  logic [ADDR_WIDTH-1:0] head_addr_q;
  logic [ADDR_WIDTH-1:0] br_tgt;

  assign br_tgt        = branch_addr_i & ALIGN_M;
  assign instr_req_o   = (state_q == WAIT_GNT);
  assign instr_addr_o  = addr_q;
  assign busy_o        = (state_q != IDLE);
  assign fetch_valid_o = (count_q != '0);
  assign fetch_rdata_o = head_data_q;
  assign fetch_addr_o  = head_addr_q;

  // Fetch FSM: issue gate, PC advance, branch redirect and discard tracking
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    disc_d  = disc_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // count never grows in IDLE, so a free slot now is still free at response time
        if (count_q < CW'(FIFO_DEPTH)) begin
          state_d = WAIT_GNT;
          addr_d  = branch_i ? br_tgt : pc_q;
        end
        if (branch_i) pc_d = br_tgt;
      end
      WAIT_GNT: begin
        if (instr_gnt_i) begin
          state_d = WAIT_RVALID;
          // after a redirect the PC already holds the target; do not step past it
          if (!disc_q) pc_d = pc_q + STEP_A;
        end
        if (branch_i) begin
          pc_d   = br_tgt;
          disc_d = 1'b1;
        end
      end
      WAIT_RVALID: begin
        if (instr_rvalid_i) begin
          push    = !disc_q && !branch_i;
          disc_d  = 1'b0;
          state_d = IDLE;
        end
        if (branch_i) begin
          pc_d = br_tgt;
          if (!instr_rvalid_i) disc_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and PC registers
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= BOOT_ADDR;
      addr_q  <= BOOT_ADDR;
      disc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      disc_q  <= disc_d;
    end
  end

  // FIFO pop and next read pointer / occupancy
  always_comb begin
    pop    = fetch_valid_o && fetch_ready_i && !branch_i;
    rd_nxt = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   cnt_nxt = count_q + CW'(1);
      2'b01:   cnt_nxt = count_q - CW'(1);
      default: cnt_nxt = count_q;
    endcase
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= instr_rdata_i;
      mem_addr_q[wr_ptr_q] <= addr_q;
    end
  end

  // FIFO pointers and head register; head holds its last value when empty
  always_ff @(posedge clk) begin
    if (rst_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      head_data_q <= '0;
      head_addr_q <= '0;
    end else if (branch_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_nxt;
      count_q  <= cnt_nxt;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (cnt_nxt != '0) begin
        // the new head is the word being written only when it becomes the sole entry
        if (push && (wr_ptr_q == rd_nxt)) begin
          head_data_q <= instr_rdata_i;
          head_addr_q <= addr_q;
        end else begin
          head_data_q <= mem_data_q[rd_nxt];
          head_addr_q <= mem_addr_q[rd_nxt];
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer with a behavioural instruction memory.
module tb_instr_prefetch_buffer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        instr_req_o;
  logic [7:0]  instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        branch_i = 1'b0;
  logic [7:0]  branch_addr_i = '0;
  logic        fetch_valid_o;
  logic [31:0] fetch_rdata_o;
  logic [7:0]  fetch_addr_o;
  logic        fetch_ready_i = 1'b0;
  logic        busy_o;

  int checks = 0;
  int failures = 0;

  // memory model knobs and observations
  int         gd = 0;
  int         rvd = 1;
  int         n_gnt = 0;
  logic [7:0] last_gnt_addr = '0;

  instr_prefetch_buffer #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .FIFO_DEPTH(4), .BOOT_ADDR(8'h00)
  ) dut (
    .clk(clk), .rst_i(rst_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i),
    .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .fetch_valid_o(fetch_valid_o), .fetch_rdata_o(fetch_rdata_o),
    .fetch_addr_o(fetch_addr_o), .fetch_ready_i(fetch_ready_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [7:0] a);
    case (a)
      8'h00:   word = 32'h00D00113;
      8'h04:   word = 32'h00900093;
      default: word = 32'hC0DE0000 | {24'h0, a};
    endcase
  endfunction

  // Instruction memory: grant after gd cycles of req, data rvd cycles after grant
  initial begin : memory
    int         g_cnt;
    int         rv_cnt;
    bit         rv_pend;
    logic [7:0] pend_addr;
    g_cnt = 0; rv_cnt = 0; rv_pend = 0; pend_addr = '0;
    forever begin
      @(negedge clk);
      instr_gnt_i    = 1'b0;
      instr_rvalid_i = 1'b0;
      if (rst_i) begin
        rv_pend = 0;
        g_cnt   = gd;
        n_gnt   = 0;
      end else if (rv_pend) begin
        if (rv_cnt == 0) begin
          instr_rvalid_i = 1'b1;
          instr_rdata_i  = word(pend_addr);
          rv_pend        = 0;
          g_cnt          = gd;
        end else rv_cnt--;
      end else if (instr_req_o) begin
        if (g_cnt == 0) begin
          instr_gnt_i   = 1'b1;
          pend_addr     = instr_addr_o;
          last_gnt_addr = instr_addr_o;
          n_gnt++;
          rv_pend       = 1;
          rv_cnt        = rvd;
        end else g_cnt--;
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_i = 1'b1;
    branch_i = 1'b0;
    tick; tick;
    rst_i = 1'b0;
  endtask

  task automatic wait_pop(output logic [7:0] a, output logic [31:0] d, output bit ok);
    ok = 0; a = '0; d = '0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (fetch_valid_o) begin
        a = fetch_addr_o; d = fetch_rdata_o; ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_gnt(input logic [7:0] a, output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (instr_gnt_i && instr_addr_o == a) begin ok = 1; break; end
    end
  endtask

  task automatic wait_ngnt(input int target, output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (n_gnt >= target) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    fetch_ready_i = 1'b0; gd = 0; rvd = 1;
    rst_i = 1'b1;
    tick; tick;
    checks++;
    if (instr_req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%b want=0", instr_req_o); end
    checks++;
    if (instr_addr_o !== 8'h00) begin failures++; $display("FAIL rst_addr got=%h want=00", instr_addr_o); end
    checks++;
    if (fetch_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL rst_valid_busy got=%b%b want=00", fetch_valid_o, busy_o);
    end
    checks++;
    if (fetch_rdata_o !== 32'h0 || fetch_addr_o !== 8'h00) begin
      failures++; $display("FAIL rst_head got=%h/%h want=00000000/00", fetch_rdata_o, fetch_addr_o);
    end
    rst_i = 1'b0;
    tick;
    checks++;
    if (instr_req_o !== 1'b1 || instr_addr_o !== 8'h00 || busy_o !== 1'b1) begin
      failures++; $display("FAIL first_req got req=%b addr=%h busy=%b want 1/00/1", instr_req_o, instr_addr_o, busy_o);
    end
  endtask

  task automatic test_in_order;
    logic [7:0] a; logic [31:0] d; bit ok;
    gd = 0; rvd = 1; fetch_ready_i = 1'b1;
    do_reset;
    wait_pop(a, d, ok);
    checks++;
    if (!ok || a !== 8'h00 || d !== 32'h00D00113) begin
      failures++; $display("FAIL order_pop0 got ok=%0b %h/%h want 00/00d00113", ok, a, d);
    end
    wait_pop(a, d, ok);
    checks++;
    if (!ok || a !== 8'h04 || d !== 32'h00900093) begin
      failures++; $display("FAIL order_pop1 got ok=%0b %h/%h want 04/00900093", ok, a, d);
    end
    fetch_ready_i = 1'b0;
  endtask

  task automatic test_backpressure;
    int base;
    gd = 0; rvd = 1; fetch_ready_i = 1'b0;
    do_reset;
    repeat (60) tick;
    checks++;
    if (n_gnt != 4 || instr_req_o !== 1'b0) begin
      failures++; $display("FAIL full_stop got gnts=%0d req=%b want 4/0", n_gnt, instr_req_o);
    end
    checks++;
    if (fetch_valid_o !== 1'b1 || fetch_addr_o !== 8'h00) begin
      failures++; $display("FAIL full_head got v=%b addr=%h want 1/00", fetch_valid_o, fetch_addr_o);
    end
    fetch_ready_i = 1'b1;
    tick;
    fetch_ready_i = 1'b0;
    base = n_gnt;
    repeat (30) tick;
    checks++;
    if (n_gnt - base != 1 || last_gnt_addr !== 8'h10) begin
      failures++; $display("FAIL refill got gnts=%0d addr=%h want 1/10", n_gnt - base, last_gnt_addr);
    end
    checks++;
    if (fetch_addr_o !== 8'h04 || fetch_rdata_o !== 32'h00900093) begin
      failures++; $display("FAIL refill_head got %h/%h want 04/00900093", fetch_addr_o, fetch_rdata_o);
    end
  endtask

  task automatic test_branch_rvalid;
    logic [7:0] a; logic [31:0] d; bit ok; int base;
    gd = 0; rvd = 5; fetch_ready_i = 1'b0;
    do_reset;
    wait_gnt(8'h08, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL br_rv_gnt8 got timeout want grant at 08"); end
    tick;
    branch_i = 1'b1; branch_addr_i = 8'h81;
    base = n_gnt;
    tick;
    branch_i = 1'b0;
    checks++;
    if (fetch_valid_o !== 1'b0) begin failures++; $display("FAIL br_rv_flush got valid=%b want 0", fetch_valid_o); end
    wait_ngnt(base + 1, ok);
    checks++;
    if (!ok || last_gnt_addr !== 8'h80) begin
      failures++; $display("FAIL br_rv_req got ok=%0b addr=%h want 80", ok, last_gnt_addr);
    end
    fetch_ready_i = 1'b1;
    wait_pop(a, d, ok);
    checks++;
    if (!ok || a !== 8'h80 || d !== 32'hC0DE0080) begin
      failures++; $display("FAIL br_rv_pop got ok=%0b %h/%h want 80/c0de0080", ok, a, d);
    end
    fetch_ready_i = 1'b0;
  endtask

  task automatic test_branch_gnt;
    logic [7:0] a; logic [31:0] d; bit ok; int base;
    gd = 3; rvd = 1; fetch_ready_i = 1'b0;
    do_reset;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (instr_req_o) begin ok = 1; break; end
    end
    base = n_gnt;
    branch_i = 1'b1; branch_addr_i = 8'h40;
    tick;
    branch_i = 1'b0;
    checks++;
    if (!ok || instr_req_o !== 1'b1 || instr_addr_o !== 8'h00) begin
      failures++; $display("FAIL br_gnt_hold got ok=%0b req=%b addr=%h want 1/00", ok, instr_req_o, instr_addr_o);
    end
    wait_ngnt(base + 1, ok);
    checks++;
    if (!ok || last_gnt_addr !== 8'h00) begin
      failures++; $display("FAIL br_gnt_old got ok=%0b addr=%h want 00", ok, last_gnt_addr);
    end
    wait_ngnt(base + 2, ok);
    checks++;
    if (!ok || last_gnt_addr !== 8'h40 || fetch_valid_o !== 1'b0) begin
      failures++; $display("FAIL br_gnt_new got ok=%0b addr=%h v=%b want 40/0", ok, last_gnt_addr, fetch_valid_o);
    end
    fetch_ready_i = 1'b1;
    wait_pop(a, d, ok);
    checks++;
    if (!ok || a !== 8'h40 || d !== 32'hC0DE0040) begin
      failures++; $display("FAIL br_gnt_pop got ok=%0b %h/%h want 40/c0de0040", ok, a, d);
    end
    fetch_ready_i = 1'b0;
    gd = 0;
  endtask

  task automatic test_wrap;
    logic [7:0] a; logic [31:0] d; bit ok;
    gd = 0; rvd = 5; fetch_ready_i = 1'b0;
    do_reset;
    wait_gnt(8'h00, ok);
    tick;
    branch_i = 1'b1; branch_addr_i = 8'hFC;
    tick;
    branch_i = 1'b0;
    fetch_ready_i = 1'b1;
    wait_pop(a, d, ok);
    checks++;
    if (!ok || a !== 8'hFC || d !== 32'hC0DE00FC) begin
      failures++; $display("FAIL wrap_top got ok=%0b %h/%h want fc/c0de00fc", ok, a, d);
    end
    wait_pop(a, d, ok);
    checks++;
    if (!ok || a !== 8'h00 || d !== 32'h00D00113) begin
      failures++; $display("FAIL wrap_zero got ok=%0b %h/%h want 00/00d00113", ok, a, d);
    end
    fetch_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [7:0] a; logic [31:0] d; bit ok;
    gd = 0; rvd = 5; fetch_ready_i = 1'b0;
    do_reset;
    wait_gnt(8'h0C, ok);
    checks++;
    if (!ok || fetch_valid_o !== 1'b1) begin
      failures++; $display("FAIL rmid_setup got ok=%0b v=%b want grant at 0c with data buffered", ok, fetch_valid_o);
    end
    tick;
    rst_i = 1'b1;
    tick;
    checks++;
    if (fetch_valid_o !== 1'b0 || instr_req_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL rmid_state got v=%b req=%b busy=%b want 000", fetch_valid_o, instr_req_o, busy_o);
    end
    checks++;
    if (instr_addr_o !== 8'h00) begin failures++; $display("FAIL rmid_addr got=%h want 00", instr_addr_o); end
    rst_i = 1'b0;
    wait_ngnt(1, ok);
    checks++;
    if (!ok || last_gnt_addr !== 8'h00) begin
      failures++; $display("FAIL rmid_boot got ok=%0b addr=%h want 00", ok, last_gnt_addr);
    end
    fetch_ready_i = 1'b1;
    wait_pop(a, d, ok);
    checks++;
    if (!ok || a !== 8'h00 || d !== 32'h00D00113) begin
      failures++; $display("FAIL rmid_pop got ok=%0b %h/%h want 00/00d00113", ok, a, d);
    end
    fetch_ready_i = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset;
    test_in_order;
    test_backpressure;
    test_branch_rvalid;
    test_branch_gnt;
    test_wrap;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
